// File: rtl/cdce62002_pkg.sv
// Shared constants, state encoding and transaction helpers for the CDCE62002 loader.
package cdce62002_pkg;

    localparam logic [3:0] REG0_ADDR = 4'h0;
    localparam logic [3:0] REG1_ADDR = 4'h1;
    localparam logic [3:0] READ_CMD  = 4'hE;
    localparam int         FRAME_LEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        GAP,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        TXN_WRITE,
        TXN_READ_CMD,
        TXN_READ_DATA
    } txn_t;

    // Transaction list: W0, W1, RC0, RD0, RC1, RD1
    function automatic txn_t txn_type(input logic [2:0] idx);
        if (idx < 3'd2) begin
            return TXN_WRITE;
        end
        return idx[0] ? TXN_READ_DATA : TXN_READ_CMD;
    endfunction

    function automatic logic [3:0] txn_addr(input logic [2:0] idx);
        logic sel;
        sel = (idx < 3'd2) ? idx[0] : idx[2];
        return sel ? REG1_ADDR : REG0_ADDR;
    endfunction

endpackage

// File: rtl/cdce62002_spi_loader_shift_engine.sv
// 32-bit LSB-first SPI shifter with SCLK half-period divider and MISO capture.
module spi_shift_engine
    import cdce62002_pkg::*;
#(
    parameter int CLK_DIV = 2
)
(
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [FRAME_LEN-1:0] load_word,
    input  logic                 in_low,
    input  logic                 in_high,
    input  logic                 miso,
    output logic                 mosi,
    output logic                 phase_end,
    output logic                 last_bit,
    output logic [27:0]          capture
);

    localparam logic [3:0] DIV_RELOAD = 4'(CLK_DIV - 1);

    logic [FRAME_LEN-1:0] sr;
    logic [4:0]           bit_cnt;
    logic [3:0]           div_cnt;
    logic                 active;
    logic                 bit_end;

    assign active    = in_low | in_high;
    assign phase_end = (div_cnt == 4'd0);
    assign last_bit  = (bit_cnt == 5'(FRAME_LEN - 1));
    assign bit_end   = in_high & phase_end;
    assign mosi      = sr[0];

    // Capture shifts in from the top so that after 32 bits it holds frame bits 31:4.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            capture <= '0;
        end else begin
            if (load) begin
                div_cnt <= DIV_RELOAD;
            end else if (active) begin
                div_cnt <= phase_end ? DIV_RELOAD : div_cnt - 4'd1;
            end

            if (load) begin
                sr      <= load_word;
                bit_cnt <= '0;
            end else if (bit_end) begin
                capture <= {miso, capture[27:1]};
                if (last_bit) begin
                    sr <= '0;
                end else begin
                    sr      <= {1'b0, sr[FRAME_LEN-1:1]};
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cdce62002_spi_loader.sv
// CDCE62002 configuration loader: writes RAM registers 0/1, optionally reads them back and verifies.
module cdce62002_spi_loader
    import cdce62002_pkg::*;
#(
    parameter logic [27:0] REG0_DATA = 28'h0000000,
    parameter logic [27:0] REG1_DATA = 28'h0000000,
    parameter int          CLK_DIV   = 2,
    parameter int          CS_GAP    = 4,
    parameter bit          VERIFY    = 1'b1
)
(
    input  logic sysclk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    output logic pll_spi_clk,
    output logic pll_spi_mosi,
    output logic pll_spi_cs_INV,
    input  logic pll_spi_miso
);

    localparam logic [2:0] LAST_IDX   = VERIFY ? 3'd5 : 3'd1;
    localparam logic [3:0] GAP_RELOAD = 4'(CS_GAP - 1);

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      idx;
    logic [2:0]      load_idx;
    logic [3:0]      gap_cnt;
    logic            gap_end;
    logic            load;
    logic            phase_end;
    logic            last_bit;
    logic            sclk_nxt;
    logic            cs_inv_nxt;
    logic [27:0]     capture;
    logic [31:0]     load_word;

    function automatic logic [31:0] frame_word(input logic [2:0] i);
        case (txn_type(i))
            TXN_WRITE:    return {(txn_addr(i) == REG1_ADDR) ? REG1_DATA : REG0_DATA, txn_addr(i)};
            TXN_READ_CMD: return {24'h0, txn_addr(i), READ_CMD};
            default:      return '0;
        endcase
    endfunction

    function automatic logic [27:0] expected_data(input logic [2:0] i);
        return (txn_addr(i) == REG1_ADDR) ? REG1_DATA : REG0_DATA;
    endfunction

    assign gap_end   = (gap_cnt == 4'd0);
    assign load_idx  = (state == IDLE) ? 3'd0 : idx + 3'd1;
    assign load_word = frame_word(load_idx);

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .sysclk    (sysclk),
        .reset     (reset),
        .load      (load),
        .load_word (load_word),
        .in_low    (state == LOW),
        .in_high   (state == HIGH),
        .miso      (pll_spi_miso),
        .mosi      (pll_spi_mosi),
        .phase_end (phase_end),
        .last_bit  (last_bit),
        .capture   (capture)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                end
            end
            SETUP: state_nxt = LOW;
            LOW: begin
                if (phase_end) state_nxt = HIGH;
            end
            HIGH: begin
                if (phase_end) state_nxt = last_bit ? GAP : LOW;
            end
            GAP: begin
                if (gap_end) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = SETUP;
                        load      = 1'b1;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // SPI pins are registered from the next state so they are glitch-free and track the FSM exactly.
        sclk_nxt   = (state_nxt == HIGH);
        cs_inv_nxt = !(state_nxt inside {SETUP, LOW, HIGH});
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            gap_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            pll_spi_clk    <= 1'b0;
            pll_spi_cs_INV <= 1'b1;
        end else begin
            state          <= state_nxt;
            pll_spi_clk    <= sclk_nxt;
            pll_spi_cs_INV <= cs_inv_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                        idx   <= '0;
                    end
                end
                HIGH: begin
                    if (phase_end && last_bit) gap_cnt <= GAP_RELOAD;
                end
                GAP: begin
                    if (!gap_end) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else begin
                        idx <= idx + 3'd1;
                        if (txn_type(idx) == TXN_READ_DATA && capture != expected_data(idx)) begin
                            error <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdce62002_spi_loader.sv
// Bench for cdce62002_spi_loader: three configurations against a behavioural CDCE62002 SPI device model.
module tb_cdce62002_spi_loader;

    localparam logic [27:0] R0_A = 28'h1234567;
    localparam logic [27:0] R1_A = 28'h89ABCDE;
    localparam logic [27:0] R0_B = 28'hAAAAAAA;
    localparam logic [27:0] R1_B = 28'h5555555;

    localparam int          DIV_CFG [3] = '{2, 2, 1};
    localparam int          GAP_CFG [3] = '{4, 4, 1};
    localparam bit          VER_CFG [3] = '{1'b0, 1'b1, 1'b1};
    localparam logic [27:0] R0_CFG  [3] = '{R0_A, R0_A, R0_B};
    localparam logic [27:0] R1_CFG  [3] = '{R1_A, R1_A, R1_B};

    logic sysclk = 1'b0;
    logic reset;
    logic start [3];
    logic busy  [3];
    logic done  [3];
    logic error [3];
    logic sclk  [3];
    logic mosi  [3];
    logic cs    [3];
    logic miso  [3];

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // device model state
    logic [31:0] frame_log  [3][$];
    int          period_log [3][$];
    int          gap_log    [3][$];
    logic [31:0] flip_mask  [3];
    int          nbit       [3];

    initial forever #5 sysclk = ~sysclk;
    initial forever begin
        @(posedge sysclk);
        cyc++;
    end

    cdce62002_spi_loader #(.REG0_DATA(R0_A), .REG1_DATA(R1_A), .CLK_DIV(2), .CS_GAP(4), .VERIFY(1'b0)) u_dut_wo (
        .sysclk(sysclk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
        .pll_spi_clk(sclk[0]), .pll_spi_mosi(mosi[0]), .pll_spi_cs_INV(cs[0]), .pll_spi_miso(miso[0]));

    cdce62002_spi_loader #(.REG0_DATA(R0_A), .REG1_DATA(R1_A), .CLK_DIV(2), .CS_GAP(4), .VERIFY(1'b1)) u_dut_vf (
        .sysclk(sysclk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
        .pll_spi_clk(sclk[1]), .pll_spi_mosi(mosi[1]), .pll_spi_cs_INV(cs[1]), .pll_spi_miso(miso[1]));

    cdce62002_spi_loader #(.REG0_DATA(R0_B), .REG1_DATA(R1_B), .CLK_DIV(1), .CS_GAP(1), .VERIFY(1'b1)) u_dut_fast (
        .sysclk(sysclk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]), .error(error[2]),
        .pll_spi_clk(sclk[2]), .pll_spi_mosi(mosi[2]), .pll_spi_cs_INV(cs[2]), .pll_spi_miso(miso[2]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Frames a CDCE62002 should see for one load, in order.
    function automatic logic [31:0] exp_frame(input int i, input int k);
        case (k)
            0:       return {R0_CFG[i], 4'h0};
            1:       return {R1_CFG[i], 4'h1};
            2:       return 32'h0000000E;
            4:       return 32'h0000001E;
            default: return 32'h00000000;
        endcase
    endfunction

    // SPI slave: samples on SCLK rise, drives MISO after each fall, holds 16 registers, echoes reads.
    initial begin
        logic [31:0] rx [3];
        logic [31:0] tx [3];
        logic [31:0] rd_word [3];
        bit          rd_next [3];
        logic        prev_cs [3];
        logic        prev_sclk [3];
        int          last_rise [3];
        int          gap_start [3];
        bit          have_rise [3];
        logic [27:0] regs [3][16];
        for (int i = 0; i < 3; i++) begin
            miso[i] = 1'b0; prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; nbit[i] = 0;
            rx[i] = '0; tx[i] = '0; rd_word[i] = '0; rd_next[i] = 1'b0;
            last_rise[i] = 0; gap_start[i] = 0; have_rise[i] = 1'b0;
            for (int r = 0; r < 16; r++) regs[i][r] = '0;
        end
        forever begin
            @(negedge sysclk);
            for (int i = 0; i < 3; i++) begin
                if (prev_cs[i] && !cs[i]) begin
                    gap_log[i].push_back(cyc - gap_start[i]);
                    nbit[i] = 0;
                    rx[i] = '0;
                    tx[i] = rd_next[i] ? rd_word[i] : 32'h0;
                    miso[i] = tx[i][0];
                end
                if (!cs[i] && sclk[i] && !prev_sclk[i]) begin
                    if (nbit[i] < 32) rx[i][nbit[i]] = mosi[i];
                    nbit[i]++;
                    if (have_rise[i]) period_log[i].push_back(cyc - last_rise[i]);
                    last_rise[i] = cyc;
                    have_rise[i] = 1'b1;
                end
                if (!cs[i] && !sclk[i] && prev_sclk[i]) begin
                    miso[i] = (nbit[i] < 32) ? tx[i][nbit[i]] : 1'b0;
                end
                if (!prev_cs[i] && cs[i]) begin
                    gap_start[i] = cyc;
                    have_rise[i] = 1'b0;
                    if (nbit[i] == 32) begin
                        frame_log[i].push_back(rx[i]);
                        if (rd_next[i]) begin
                            rd_next[i] = 1'b0;
                        end else if (rx[i][3:0] == 4'hE) begin
                            rd_next[i] = 1'b1;
                            rd_word[i] = {regs[i][rx[i][7:4]], rx[i][7:4]} ^
                                         ((rx[i][7:4] == 4'h1) ? flip_mask[i] : 32'h0);
                        end else begin
                            regs[i][rx[i][3:0]] = rx[i][31:4];
                        end
                    end else begin
                        rd_next[i] = 1'b0;
                    end
                end
                prev_cs[i]   = cs[i];
                prev_sclk[i] = sclk[i];
            end
        end
    end

    task automatic pulse_start(input int i);
        @(negedge sysclk);
        start[i] = 1'b1;
        @(negedge sysclk);
        start[i] = 1'b0;
    endtask

    // One complete load on instance i; poke >= 0 re-pulses start while that frame index is on the wire.
    task automatic run_load(input int i, input logic [31:0] flip, input int poke);
        int bf, bp, bg, n, ntx, lat, pmin, pmax, gmin, gmax;
        bit poked;
        bit exp_err;
        logic [31:0] obs;
        ntx     = VER_CFG[i] ? 6 : 2;
        lat     = ntx * (1 + 64 * DIV_CFG[i] + GAP_CFG[i]) + 1;
        exp_err = VER_CFG[i] && (flip[31:4] != 28'h0);
        flip_mask[i] = flip;
        bf = frame_log[i].size();
        bp = period_log[i].size();
        bg = gap_log[i].size();
        pulse_start(i);
        check_eq($sformatf("start_busy_i%0d", i), busy[i], 1'b1);
        check_eq($sformatf("start_clr_done_i%0d", i), done[i], 1'b0);
        check_eq($sformatf("start_clr_err_i%0d", i), error[i], 1'b0);
        n = 0;
        poked = 1'b0;
        while (n < lat + 50) begin
            @(posedge sysclk);
            n++;
            @(negedge sysclk);
            if (start[i]) start[i] = 1'b0;
            if (poke >= 0 && !poked && frame_log[i].size() == bf + poke && !cs[i]) begin
                start[i] = 1'b1;
                poked = 1'b1;
            end
            if (!busy[i]) break;
        end
        start[i] = 1'b0;
        check_eq($sformatf("latency_i%0d", i), n, lat);
        check_eq($sformatf("done_i%0d", i), done[i], 1'b1);
        check_eq($sformatf("error_i%0d_flip%h", i, flip), error[i], exp_err);
        check_eq($sformatf("idle_cs_i%0d", i), cs[i], 1'b1);
        check_eq($sformatf("nframes_i%0d", i), frame_log[i].size() - bf, ntx);
        for (int k = 0; k < ntx; k++) begin
            obs = (bf + k < frame_log[i].size()) ? frame_log[i][bf + k] : 32'hxxxxxxxx;
            check_eq($sformatf("frame%0d_i%0d", k, i), obs, exp_frame(i, k));
        end
        pmin = 9999; pmax = 0;
        for (int p = bp; p < period_log[i].size(); p++) begin
            if (period_log[i][p] < pmin) pmin = period_log[i][p];
            if (period_log[i][p] > pmax) pmax = period_log[i][p];
        end
        check_eq($sformatf("sclk_period_min_i%0d", i), pmin, 2 * DIV_CFG[i]);
        check_eq($sformatf("sclk_period_max_i%0d", i), pmax, 2 * DIV_CFG[i]);
        gmin = 9999; gmax = 0;
        for (int g = bg + 1; g < gap_log[i].size(); g++) begin
            if (gap_log[i][g] < gmin) gmin = gap_log[i][g];
            if (gap_log[i][g] > gmax) gmax = gap_log[i][g];
        end
        check_eq($sformatf("cs_gap_min_i%0d", i), gmin, GAP_CFG[i]);
        check_eq($sformatf("cs_gap_max_i%0d", i), gmax, GAP_CFG[i]);
    endtask

    initial begin
        int bf;
        bit found;
        int bitpos;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            flip_mask[i] = 32'h0;
        end
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_busy_i%0d", i), busy[i], 1'b0);
            check_eq($sformatf("rst_done_i%0d", i), done[i], 1'b0);
            check_eq($sformatf("rst_err_i%0d", i), error[i], 1'b0);
            check_eq($sformatf("rst_sclk_i%0d", i), sclk[i], 1'b0);
            check_eq($sformatf("rst_mosi_i%0d", i), mosi[i], 1'b0);
            check_eq($sformatf("rst_cs_i%0d", i), cs[i], 1'b1);
        end
        reset = 1'b0;
        repeat (2) @(negedge sysclk);

        run_load(0, 32'h0, -1);
        run_load(1, 32'h0, -1);

        // readback of register 1 corrupted at bit 8, then a clean restart clears the flags
        run_load(1, 32'h00000100, -1);
        run_load(1, 32'h0, -1);

        // abort during bit 17 of W1
        bf = frame_log[1].size();
        pulse_start(1);
        found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            @(negedge sysclk);
            if (frame_log[1].size() == bf + 1 && nbit[1] == 18 && sclk[1]) found = 1'b1;
        end
        check_eq("abort_point_reached", found, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("abort_cs", cs[1], 1'b1);
        check_eq("abort_sclk", sclk[1], 1'b0);
        check_eq("abort_busy", busy[1], 1'b0);
        @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        check_eq("abort_partial_dropped", frame_log[1].size() - bf, 1);
        run_load(1, 32'h0, -1);

        // start while busy during frame 3 is ignored
        run_load(1, 32'h0, 2);

        run_load(2, 32'h0, -1);
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 7)) @(negedge sysclk);
            bitpos = $urandom_range(0, 31);
            run_load((r % 2 == 0) ? 2 : 1, 32'h1 << bitpos, ($urandom_range(0, 3) == 0) ? 1 : -1);
        end
        run_load(2, 32'h0000000F, -1);
        run_load(0, 32'h0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
